core_id_scoreboard: RTL and testbench
=====================================

CORE_ID_SCOREBOARD -- requirements
Module: core_id_scoreboard

Interface
REQ-001 SHALL have parameter: MAX_INFLIGHT, 8, maximum issued-but-unreleased instructions (2..15).
REQ-002 SHALL have parameter: PEND_W, 2, width of each per-register pending counter.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_valid  in  1  decoded instruction present; id_ready  out  1  decode stage may advance.
REQ-005 SHALL have ports: ex_valid  out  1  issue to execute; ex_ready  in  1  execute accepts.
REQ-006 SHALL have ports: rs1_ren, rs2_ren, rd_wen  in  1 each; rs1_idx, rs2_idx, rd_idx  in  5 each  decoded operand fields.
REQ-007 SHALL have ports: id_serialize  in  1  instruction requires empty pipeline (fence/CSR).
REQ-008 SHALL have ports: wb_valid  in  1  one issued instruction leaves pipeline; wb_claim  in  1  it had claimed a rd; wb_idx  in  5  that rd.
REQ-009 SHALL have ports: flush  in  1  mispredict kill of decode slot; sb_state  out  2  FSM state; inflight  out  4  outstanding count; sb_err  out  1  sticky release-underflow flag.

Function
REQ-010 SHALL hold one PEND_W-bit pending counter per register x1..x31; x0 never claimed and never hazards.
REQ-011 SHALL define issue = ex_valid & ex_ready; on issue with rd_wen & rd_idx!=0, counter[rd_idx] increments.
REQ-012 SHALL decrement counter[wb_idx] on wb_valid & wb_claim & wb_idx!=0; killed instructions still release via wb_valid.
REQ-013 SHALL leave counter unchanged on simultaneous claim and release of the same register.
REQ-014 SHALL increment inflight on issue and decrement on wb_valid; simultaneous issue and wb_valid leave it unchanged.
REQ-015 SHALL evaluate hazards from registered counters only; same-cycle release does not clear a hazard (one bubble minimum).
REQ-016 SHALL flag RAW hazard when (rs1_ren & counter[rs1_idx]!=0) or (rs2_ren & counter[rs2_idx]!=0).
REQ-017 SHALL flag capacity hazard when inflight==MAX_INFLIGHT, or rd_wen & counter[rd_idx] at all-ones.
REQ-018 SHALL flag serialize hazard when id_serialize & inflight!=0.
REQ-019 SHALL drive ex_valid = id_valid & ~hazard & ~flush and id_ready = (ex_ready & ~hazard) | flush, combinationally.
REQ-020 SHALL, on flush, drop the decode-slot instruction: no issue, no claim, counters unaffected, state forced to RUN next cycle.
REQ-021 SHALL implement FSM: RUN=0, STALL=1, DRAIN=2.
REQ-022 SHALL transition RUN->STALL when id_valid & (RAW or capacity hazard) & ~flush.
REQ-023 SHALL transition RUN->DRAIN when id_valid & serialize hazard & ~flush; serialize takes precedence over STALL.
REQ-024 SHALL transition STALL->RUN when no hazard remains or id_valid drops; DRAIN->RUN when inflight==0.
REQ-025 SHALL, on wb release with counter 0 or wb_valid with inflight 0, ignore the decrement and set sb_err until reset.

Reset
REQ-026 SHALL, on rst high at a clk edge, clear all counters and inflight, set sb_state=RUN and sb_err=0; rst overrides all same-cycle issue/release.
REQ-027 SHALL, during rst, drive ex_valid=0 and id_ready=0.

Configuration
REQ-028 SHALL, when CORE_SB_WAW_CHECK_EN is defined, also flag hazard (STALL) when rd_wen & rd_idx!=0 & counter[rd_idx]!=0.
REQ-029 SHALL, when CORE_SB_WAW_CHECK_EN is undefined, permit multiple outstanding writes to one register, limited only by REQ-017.

Verification
REQ-030 SHALL test: issue rd=x5, then rs1=x5 next cycle -> ex_valid=0, sb_state=STALL; wb_valid wb_idx=5 -> ex_valid=1 the following cycle.
REQ-031 SHALL test: 8 issues with no wb, ex_ready=1 -> 9th held, inflight=8; one wb_valid -> 9th issues next cycle.
REQ-032 SHALL test: inflight=3, id_serialize=1 -> sb_state=DRAIN; 3 releases -> sb_state=RUN, ex_valid=1 next cycle.
REQ-033 SHALL test: same cycle issue rd=x7 and wb_idx=7 with counter[7]=1 -> counter[7] stays 1; rs1=x7 stalls.
REQ-034 SHALL test: flush during STALL -> ex_valid=0, id_ready=1, sb_state=RUN next cycle; wb_valid with inflight=0 -> sb_err=1, inflight stays 0.
REQ-035 SHALL test: with CORE_SB_WAW_CHECK_EN, issue rd=x3 then rd=x3 -> second stalls; without it -> second issues, counter[3]=2.

Source files
------------

// File: rtl/core_id_scoreboard.sv
// rtl/core_id_scoreboard.sv - decode-to-execute register scoreboard with RAW, capacity and serialize interlocks
// Optional build macro: CORE_SB_WAW_CHECK_EN (also interlock on outstanding writes to the same rd).
module core_id_scoreboard #(
    parameter int MAX_INFLIGHT = 8,
    parameter int PEND_W       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    output logic       id_ready,
    output logic       ex_valid,
    input  logic       ex_ready,
    input  logic       rs1_ren,
    input  logic       rs2_ren,
    input  logic       rd_wen,
    input  logic [4:0] rs1_idx,
    input  logic [4:0] rs2_idx,
    input  logic [4:0] rd_idx,
    input  logic       id_serialize,
    input  logic       wb_valid,
    input  logic       wb_claim,
    input  logic [4:0] wb_idx,
    input  logic       flush,
    output logic [1:0] sb_state,
    output logic [3:0] inflight,
    output logic       sb_err
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [3:0]        MAX_CNT  = 4'(MAX_INFLIGHT);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // Entry 0 is held at zero so x0 can never hazard or be claimed.
    logic [PEND_W-1:0] pend [0:31];

    logic        raw_hz;
    logic        cap_hz;
    logic        ser_hz;
    logic        waw_hz;
    logic        hazard;
    logic        issue;
    logic        rel_req;
    logic        rel_ok;
    logic        wb_ok;
    logic [31:0] claim_vec;
    logic [31:0] rel_vec;
    logic [1:0]  state_nxt;

    always_comb begin
        raw_hz = (rs1_ren && (pend[rs1_idx] != '0)) || (rs2_ren && (pend[rs2_idx] != '0));
        cap_hz = (inflight == MAX_CNT) || (rd_wen && (pend[rd_idx] == PEND_MAX));
        ser_hz = id_serialize && (inflight != 4'd0);
`ifdef CORE_SB_WAW_CHECK_EN
        waw_hz = rd_wen && (rd_idx != 5'd0) && (pend[rd_idx] != '0);
`else
        waw_hz = 1'b0;
`endif
        hazard = raw_hz || cap_hz || ser_hz || waw_hz;
    end

    assign ex_valid = !rst && id_valid && !hazard && !flush;
    assign id_ready = !rst && ((ex_ready && !hazard) || flush);
    assign issue    = ex_valid && ex_ready;

    // A release against an idle counter (or empty pipeline) is a protocol error and is dropped.
    assign rel_req = wb_valid && wb_claim && (wb_idx != 5'd0);
    assign rel_ok  = rel_req && (pend[wb_idx] != '0);
    assign wb_ok   = wb_valid && (inflight != 4'd0);

    always_comb begin
        claim_vec = '0;
        rel_vec   = '0;
        if (issue && rd_wen && (rd_idx != 5'd0)) begin
            claim_vec = 32'd1 << rd_idx;
        end
        if (rel_ok) begin
            rel_vec = 32'd1 << wb_idx;
        end
    end

    always_comb begin
        state_nxt = sb_state;
        if (flush) begin
            state_nxt = ST_RUN;
        end else begin
            case (sb_state)
                ST_RUN: begin
                    if (id_valid && ser_hz) begin
                        state_nxt = ST_DRAIN;
                    end else if (id_valid && (raw_hz || cap_hz || waw_hz)) begin
                        state_nxt = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!id_valid || !hazard) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight == 4'd0) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                pend[i] <= '0;
            end
            inflight <= 4'd0;
            sb_state <= ST_RUN;
            sb_err   <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (claim_vec[i] && !rel_vec[i]) begin
                    pend[i] <= pend[i] + PEND_ONE;
                end else if (rel_vec[i] && !claim_vec[i]) begin
                    pend[i] <= pend[i] - PEND_ONE;
                end
            end
            if (issue && !wb_ok) begin
                inflight <= inflight + 4'd1;
            end else if (wb_ok && !issue) begin
                inflight <= inflight - 4'd1;
            end
            sb_state <= state_nxt;
            if ((rel_req && !rel_ok) || (wb_valid && !wb_ok)) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_id_scoreboard.sv
// tb/tb_core_id_scoreboard.sv - directed self-checking bench for core_id_scoreboard
module tb_core_id_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic       id_ready;
    logic       ex_valid;
    logic       ex_ready;
    logic       rs1_ren;
    logic       rs2_ren;
    logic       rd_wen;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;
    logic       id_serialize;
    logic       wb_valid;
    logic       wb_claim;
    logic [4:0] wb_idx;
    logic       flush;
    logic [1:0] sb_state;
    logic [3:0] inflight;
    logic       sb_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_id_scoreboard #(.MAX_INFLIGHT(8), .PEND_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .rs1_ren      (rs1_ren),
        .rs2_ren      (rs2_ren),
        .rd_wen       (rd_wen),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .rd_idx       (rd_idx),
        .id_serialize (id_serialize),
        .wb_valid     (wb_valid),
        .wb_claim     (wb_claim),
        .wb_idx       (wb_idx),
        .flush        (flush),
        .sb_state     (sb_state),
        .inflight     (inflight),
        .sb_err       (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        id_valid = 0; rs1_ren = 0; rs2_ren = 0; rd_wen = 0;
        rs1_idx = 0; rs2_idx = 0; rd_idx = 0; id_serialize = 0;
        wb_valid = 0; wb_claim = 0; wb_idx = 0; flush = 0;
    endtask

    task automatic instr(input logic rd_en, input logic [4:0] rd, input logic r1_en, input logic [4:0] r1);
        idle();
        id_valid = 1; rd_wen = rd_en; rd_idx = rd; rs1_ren = r1_en; rs1_idx = r1;
    endtask

    task automatic release_one(input logic claim, input logic [4:0] idx);
        wb_valid = 1; wb_claim = claim; wb_idx = idx;
        tick();
        wb_valid = 0; wb_claim = 0; wb_idx = 0;
    endtask

    initial begin
        idle();
        ex_ready = 1;
        rst = 1;
        id_valid = 1;
        settle();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_id_ready", id_ready, 0);
        tick();
        tick();
        rst = 0;
        idle();
        settle();
        check("rst_state", sb_state, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", sb_err, 0);

        // RAW on x5: stall, release, issue one bubble later
        instr(1, 5'd5, 0, 0);
        settle();
        check("raw_first_issue", ex_valid, 1);
        tick();
        instr(0, 0, 1, 5'd5);
        settle();
        check("raw_stall_ex_valid", ex_valid, 0);
        check("raw_stall_id_ready", id_ready, 0);
        tick();
        check("raw_state_stall", sb_state, 1);
        wb_valid = 1; wb_claim = 1; wb_idx = 5'd5;
        settle();
        check("raw_same_cycle_release", ex_valid, 0);
        tick();
        wb_valid = 0; wb_claim = 0; wb_idx = 0;
        settle();
        check("raw_after_release", ex_valid, 1);
        tick();
        check("raw_state_run", sb_state, 0);
        check("raw_inflight", inflight, 1);
        idle();
        release_one(0, 0);
        check("raw_drained", inflight, 0);

        // Capacity: eight issues fill the window, ninth waits for a writeback
        instr(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick();
        check("cap_inflight_full", inflight, 8);
        check("cap_ninth_held", ex_valid, 0);
        tick();
        check("cap_state_stall", sb_state, 1);
        wb_valid = 1; wb_claim = 0;
        tick();
        wb_valid = 0;
        settle();
        check("cap_ninth_ready", ex_valid, 1);
        tick();
        check("cap_inflight_refill", inflight, 8);
        idle();
        for (int i = 0; i < 8; i++) release_one(0, 0);
        check("cap_drained", inflight, 0);

        // Serialize: wait for three outstanding to drain
        instr(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("ser_inflight3", inflight, 3);
        id_serialize = 1;
        settle();
        check("ser_held", ex_valid, 0);
        tick();
        check("ser_state_drain", sb_state, 2);
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1;
            tick();
        end
        wb_valid = 0;
        settle();
        check("ser_inflight0", inflight, 0);
        check("ser_issue_ready", ex_valid, 1);
        tick();
        check("ser_state_run", sb_state, 0);
        idle();
        release_one(0, 0);

`ifndef CORE_SB_WAW_CHECK_EN
        // Simultaneous claim and release of x7 keeps counter at 1
        instr(1, 5'd7, 0, 0);
        tick();
        wb_valid = 1; wb_claim = 1; wb_idx = 5'd7;
        settle();
        check("x7_second_issue", ex_valid, 1);
        tick();
        wb_valid = 0; wb_claim = 0; wb_idx = 0;
        check("x7_inflight", inflight, 1);
        instr(0, 0, 1, 5'd7);
        settle();
        check("x7_read_stalls", ex_valid, 0);
        tick();
        check("x7_state_stall", sb_state, 1);

        // Flush during STALL
        flush = 1;
        settle();
        check("flush_ex_valid", ex_valid, 0);
        check("flush_id_ready", id_ready, 1);
        tick();
        check("flush_state_run", sb_state, 0);
        check("flush_inflight", inflight, 1);
        idle();
        release_one(1, 5'd7);
        check("x7_released", inflight, 0);
`endif

        // Writeback with nothing in flight
        check("err_before", sb_err, 0);
        release_one(0, 0);
        check("err_set", sb_err, 1);
        check("err_inflight0", inflight, 0);
        tick();
        check("err_sticky", sb_err, 1);

        // Repeated rd=x3
        instr(1, 5'd3, 0, 0);
        settle();
        check("waw_first", ex_valid, 1);
        tick();
`ifdef CORE_SB_WAW_CHECK_EN
        settle();
        check("waw_second_stalls", ex_valid, 0);
        idle();
        release_one(1, 5'd3);
        instr(1, 5'd3, 0, 0);
        settle();
        check("waw_after_release", ex_valid, 1);
        tick();
        idle();
        release_one(1, 5'd3);
        check("waw_drained", inflight, 0);
`else
        settle();
        check("waw_second_issues", ex_valid, 1);
        tick();
        check("waw_third_issues", ex_valid, 1);
        tick();
        check("x3_counter_full", ex_valid, 0);
        check("x3_inflight3", inflight, 3);
        idle();
        release_one(1, 5'd3);
        instr(0, 0, 1, 5'd3);
        settle();
        check("x3_count2_stall", ex_valid, 0);
        idle();
        release_one(1, 5'd3);
        instr(0, 0, 1, 5'd3);
        settle();
        check("x3_count1_stall", ex_valid, 0);
        idle();
        release_one(1, 5'd3);
        instr(0, 0, 1, 5'd3);
        settle();
        check("x3_count0_issue", ex_valid, 1);
        idle();
        check("x3_inflight0", inflight, 0);
`endif

        rst = 1;
        tick();
        rst = 0;
        check("final_rst_err", sb_err, 0);
        check("final_rst_inflight", inflight, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
